// File: rtl/vga_rect_fill.sv
// Rectangle fill pixel generator for the vga_adapter plot interface: one clipped pixel per clock in raster order.
// Optional macro VGA_RECT_FILL_CLEAR_EN adds a clear input that fills the whole screen with colour 0.
module vga_rect_fill #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3,
  parameter int X_MAX        = 159,
  parameter int Y_MAX        = 119
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
`ifdef VGA_RECT_FILL_CLEAR_EN
  input  logic                    clear,
`endif
  input  logic [X_WIDTH-1:0]      x0,
  input  logic [Y_WIDTH-1:0]      y0,
  input  logic [X_WIDTH-1:0]      width,
  input  logic [Y_WIDTH-1:0]      height,
  input  logic [COLOUR_WIDTH-1:0] colour_in,
  output logic                    busy,
  output logic                    done,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot
);

  // state | meaning
  // IDLE  | waiting for start (or clear); plot=0, x/y hold
  // FILL  | presenting one pixel per cycle
  // DONE  | completion; done pulses for one cycle, busy still high
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [X_WIDTH:0]   X_MAX_W = (X_WIDTH+1)'(X_MAX);
  localparam logic [Y_WIDTH:0]   Y_MAX_W = (Y_WIDTH+1)'(Y_MAX);
  localparam logic [X_WIDTH:0]   X_ONE_W = (X_WIDTH+1)'(1);
  localparam logic [Y_WIDTH:0]   Y_ONE_W = (Y_WIDTH+1)'(1);
  localparam logic [X_WIDTH-1:0] X_ONE   = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] Y_ONE   = Y_WIDTH'(1);
  localparam logic [X_WIDTH-1:0] X_MAX_N = X_MAX_W[X_WIDTH-1:0];
  localparam logic [Y_WIDTH-1:0] Y_MAX_N = Y_MAX_W[Y_WIDTH-1:0];

  state_t                  state;
  logic [X_WIDTH-1:0]      x_start;
  logic [X_WIDTH-1:0]      x_end;
  logic [Y_WIDTH-1:0]      y_end;

  logic                    go;
  logic                    degen;
  logic [X_WIDTH-1:0]      req_x0;
  logic [Y_WIDTH-1:0]      req_y0;
  logic [X_WIDTH-1:0]      req_xe;
  logic [Y_WIDTH-1:0]      req_ye;
  logic [COLOUR_WIDTH-1:0] req_c;
  logic [X_WIDTH:0]        x_sum;
  logic [Y_WIDTH:0]        y_sum;

  // End coordinates use one extra bit so x0+width-1 cannot wrap before clipping.
  always_comb begin
    x_sum  = {1'b0, x0} + {1'b0, width} - X_ONE_W;
    y_sum  = {1'b0, y0} + {1'b0, height} - Y_ONE_W;
    go     = start;
    req_x0 = x0;
    req_y0 = y0;
    req_c  = colour_in;
    req_xe = (x_sum > X_MAX_W) ? X_MAX_N : x_sum[X_WIDTH-1:0];
    req_ye = (y_sum > Y_MAX_W) ? Y_MAX_N : y_sum[Y_WIDTH-1:0];
    degen  = (width == '0) || (height == '0) ||
             ({1'b0, x0} > X_MAX_W) || ({1'b0, y0} > Y_MAX_W);
`ifdef VGA_RECT_FILL_CLEAR_EN
    if (clear) begin
      go     = 1'b1;
      req_x0 = '0;
      req_y0 = '0;
      req_c  = '0;
      req_xe = X_MAX_N;
      req_ye = Y_MAX_N;
      degen  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          plot <= 1'b0;
          if (go) begin
            busy    <= 1'b1;
            x_start <= req_x0;
            x_end   <= req_xe;
            y_end   <= req_ye;
            colour  <= req_c;
            if (degen) begin
              state <= DONE;
            end else begin
              state <= FILL;
              x     <= req_x0;
              y     <= req_y0;
              plot  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (x == x_end && y == y_end) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else if (x < x_end) begin
            x <= x + X_ONE;
          end else begin
            x <= x_start;
            y <= y + Y_ONE;
          end
        end
        DONE: begin
          // A degenerate request arrives here with done low and spends one extra cycle.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill: a raster-order pixel model feeds a queue that a negedge monitor drains.
// Define VGA_RECT_FILL_CLEAR_EN to also exercise the full-screen clear.
module tb_vga_rect_fill;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] width = '0;
  logic [6:0] height = '0;
  logic [2:0] colour_in = '0;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  vga_rect_fill dut (
    .clock(clock), .reset(reset), .start(start),
`ifdef VGA_RECT_FILL_CLEAR_EN
    .clear(clear),
`endif
    .x0(x0), .y0(y0), .width(width), .height(height), .colour_in(colour_in),
    .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [17:0] pix_q[$];
  int exp_done = 0;
  int prev_x = 0;
  int prev_y = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: clipped rectangle in raster order, straight from the rectangle definition.
  task automatic model(input int rx, input int ry, input int rw, input int rh, input int rc,
                       output int npix, output int lx, output int ly);
    int xe, ye;
    npix = 0;
    lx = prev_x;
    ly = prev_y;
    if (rw == 0 || rh == 0 || rx > 159 || ry > 119) return;
    xe = (rx + rw - 1 > 159) ? 159 : rx + rw - 1;
    ye = (ry + rh - 1 > 119) ? 119 : ry + rh - 1;
    for (int yy = ry; yy <= ye; yy++)
      for (int xx = rx; xx <= xe; xx++) begin
        pix_q.push_back({8'(xx), 7'(yy), 3'(rc)});
        npix++;
      end
    lx = xe;
    ly = ye;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (plot) begin
        if (pix_q.size() == 0) check("unexpected_plot", {14'd0, x, y, colour}, 32'hFFFF_FFFF);
        else check("pixel", {14'd0, x, y, colour}, {14'd0, pix_q.pop_front()});
      end
      if (done) begin
        check("done_expected", (exp_done > 0) ? 1 : 0, 1);
        check("done_after_all_pixels", pix_q.size(), 0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic run_rect(input int rx, input int ry, input int rw, input int rh, input int rc,
                          input bit inject, input bit use_clear);
    int npix, lx, ly, lat, k, t0;
    if (use_clear) model(0, 0, 160, 120, 0, npix, lx, ly);
    else model(rx, ry, rw, rh, rc, npix, lx, ly);
    exp_done++;
    lat = (npix == 0) ? 2 : npix + 1;
    @(negedge clock);
    x0 = 8'(rx); y0 = 7'(ry); width = 8'(rw); height = 7'(rh); colour_in = 3'(rc);
    start = 1'b1;
    clear = use_clear;
    t0 = cyc;
    @(negedge clock);
    start = 1'b0;
    clear = 1'b0;
    check("busy_after_start", busy, 1);
    k = 0;
    while (!done && k < npix + 30) begin
      start = (inject && k == 2);
      colour_in = inject ? 3'd2 : 3'($urandom);
      x0 = 8'($urandom);
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
    else check("done_latency", cyc - t0, lat);
    @(negedge clock);
    check("busy_low_after_done", {busy, done, plot}, 0);
    check("xy_hold", {x, y}, {8'(lx), 7'(ly)});
    check("all_pixels_seen", pix_q.size(), 0);
    prev_x = lx;
    prev_y = ly;
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  initial begin
    int n, lx, ly, t0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", plot, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    reset = 1'b0;

    run_rect(10, 10, 3, 2, 5, 1'b0, 1'b0);
    run_rect(158, 118, 5, 4, 3, 1'b0, 1'b0);
    run_rect(20, 30, 0, 4, 1, 1'b0, 1'b0);
    run_rect(200, 5, 3, 1, 6, 1'b0, 1'b0);
    run_rect(40, 121, 3, 2, 6, 1'b0, 1'b0);
    run_rect(10, 10, 3, 2, 5, 1'b1, 1'b0);
    run_rect(159, 119, 1, 1, 7, 1'b0, 1'b0);

    // Reset after the third pixel of a 10x10 fill.
    model(50, 50, 10, 10, 4, n, lx, ly);
    exp_done++;
    @(negedge clock);
    x0 = 8'd50; y0 = 7'd50; width = 8'd10; height = 7'd10; colour_in = 3'd4; start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_outputs", {busy, done, plot}, 0);
    pix_q.delete();
    exp_done = 0;
    reset = 1'b0;
    prev_x = 0;
    prev_y = 0;
    repeat (5) @(negedge clock);
    check("midreset_quiet", {busy, done, plot}, 0);
    run_rect(0, 0, 4, 3, 2, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++)
      run_rect($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 12),
               $urandom_range(0, 8), $urandom_range(0, 7), 1'b0, 1'b0);

`ifdef VGA_RECT_FILL_CLEAR_EN
    run_rect(10, 10, 3, 2, 5, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
